// File: rtl/vga_board_capture.sv
// vga_board_capture: recovers raster timing from TinyVGA sync and commits one 16x16 board per valid frame
module vga_board_capture #(
    parameter int CAP_X0     = 256,
    parameter int CAP_Y0     = 256,
    parameter int SAMPLE_OFS = 3,
    parameter int H_TOTAL    = 800,
    parameter int H_SYNC     = 656,
    parameter int V_TOTAL    = 525,
    parameter int V_SYNC     = 490
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  vga_in,
    input  logic [7:0]  rd_addr,
    output logic        rd_data,
    output logic        locked,
    output logic        frame_done,
    output logic [8:0]  alive_count,
    output logic        changed,
    output logic [15:0] frame_count
);
    typedef enum logic [1:0] {UNLOCKED, ARMED, LOCKED} state_t;

    localparam logic [9:0] CX     = 10'(CAP_X0);
    localparam logic [9:0] CY     = 10'(CAP_Y0);
    localparam logic [9:0] CY_END = 10'(CAP_Y0 + 128);
    localparam logic [2:0] OFS    = 3'(SAMPLE_OFS);
    localparam logic [9:0] HT     = 10'(H_TOTAL - 1);
    localparam logic [9:0] HS     = 10'(H_SYNC);
    localparam logic [9:0] VT     = 10'(V_TOTAL - 1);
    localparam logic [9:0] VS     = 10'(V_SYNC);

    state_t       state_q, state_d;
    logic [7:0]   vq_q;
    logic [1:0]   sync_p_q;
    logic [9:0]   hx_q, hx_d, vy_q, vy_d, hx_e, vy_e;
    logic         hs_fall, vs_fall, h_ok, v_ok, load_v, load_h, is_locked;
    logic         samp, alive, run_start, commit;
    logic         frame_ok_q, frame_ok_d, first_q;
    logic [7:0]   idx;
    logic [8:0]   cnt_q, cnt_d;
    logic [255:0] cap_q, board_q;
    logic         rd_q, fd_q, chg_q;
    logic [8:0]   alive_q;
    logic [15:0]  fc_q;
    logic         unused_bits;

    assign unused_bits = ^{vq_q[6:5], vq_q[2:1]};

    assign hs_fall   = sync_p_q[1] & ~vq_q[7];
    assign vs_fall   = sync_p_q[0] & ~vq_q[3];
    assign h_ok      = hx_q == HS;
    assign v_ok      = hx_q == 10'd0 && vy_q == VS;
    assign is_locked = state_q == LOCKED;

    // Lock tracking: a vsync edge seeds the counters, the following hsync edge confirms them
    always_comb begin
        state_d = state_q;
        load_v  = 1'b0;
        load_h  = 1'b0;
        case (state_q)
            UNLOCKED: begin
                if (vs_fall) begin
                    state_d = ARMED;
                    load_v  = 1'b1;
                end
            end
            ARMED: begin
                if (hs_fall) begin
                    if (h_ok) state_d = LOCKED;
                    else load_h = 1'b1;
                end
            end
            LOCKED: begin
                if (vs_fall && !v_ok) begin
                    state_d = ARMED;
                    load_v  = 1'b1;
                end else if (hs_fall && !h_ok) begin
                    state_d = UNLOCKED;
                end
            end
            default: state_d = UNLOCKED;
        endcase
    end

    // Raster counters; a load re-labels the current sample, so counting resumes from the loaded point
    always_comb begin
        hx_e = load_v ? 10'd0 : (load_h ? HS : hx_q);
        vy_e = load_v ? VS : vy_q;
        hx_d = (hx_e == HT) ? 10'd0 : hx_e + 10'd1;
        vy_d = (hx_e != HT) ? vy_e : ((vy_e == VT) ? 10'd0 : vy_e + 10'd1);
    end

    // Window sampling, running count and frame validity
    always_comb begin
        samp       = hx_q[9:7] == CX[9:7] && vy_q[9:7] == CY[9:7] && hx_q[2:0] == OFS && vy_q[2:0] == OFS;
        alive      = vq_q[0] & vq_q[4];
        idx        = {vy_q[6:3], hx_q[6:3]};
        run_start  = hx_q == 10'd0 && vy_q == CY;
        commit     = hx_q == 10'd0 && vy_q == CY_END && frame_ok_q && is_locked;
        cnt_d      = (run_start ? 9'd0 : cnt_q) + {8'd0, samp & alive};
        frame_ok_d = !is_locked ? 1'b0 : (run_start ? 1'b1 : frame_ok_q);
    end

    // Input register, sync history, FSM and counter state
    always_ff @(posedge clk) begin
        if (reset) begin
            vq_q       <= 8'h88;
            sync_p_q   <= 2'b11;
            state_q    <= UNLOCKED;
            hx_q       <= 10'd0;
            vy_q       <= 10'd0;
            cnt_q      <= 9'd0;
            frame_ok_q <= 1'b0;
        end else begin
            vq_q       <= vga_in;
            sync_p_q   <= {vq_q[7], vq_q[3]};
            state_q    <= state_d;
            hx_q       <= hx_d;
            vy_q       <= vy_d;
            cnt_q      <= cnt_d;
            frame_ok_q <= frame_ok_d;
        end
    end

    // Capture buffer fills one cell per sample point
    always_ff @(posedge clk) begin
        if (reset) cap_q <= '0;
        else if (samp) cap_q[idx] <= alive;
    end

    // Commit of board and statistics, plus the registered read port
    always_ff @(posedge clk) begin
        if (reset) begin
            board_q <= '0;
            first_q <= 1'b1;
            fd_q    <= 1'b0;
            alive_q <= 9'd0;
            chg_q   <= 1'b0;
            fc_q    <= 16'd0;
            rd_q    <= 1'b0;
        end else begin
            fd_q <= commit;
            rd_q <= board_q[rd_addr];
            if (commit) begin
                board_q <= cap_q;
                first_q <= 1'b0;
                alive_q <= cnt_q;
                chg_q   <= first_q | (cap_q != board_q);
                fc_q    <= fc_q + 16'd1;
            end
        end
    end

    assign locked      = is_locked;
    assign rd_data     = rd_q;
    assign frame_done  = fd_q;
    assign alive_count = alive_q;
    assign changed     = chg_q;
    assign frame_count = fc_q;
endmodule

// File: tb/tb_vga_board_capture.sv
// tb_vga_board_capture: directed raster stimulus on a compact timing model with hand-computed board results
module tb_vga_board_capture;
    localparam int HT = 140;
    localparam int HS = 130;
    localparam int VT = 131;
    localparam int VS = 129;

    logic        clk;
    logic        reset;
    logic [7:0]  vga_in;
    logic [7:0]  rd_addr;
    logic        rd_data;
    logic        locked;
    logic        frame_done;
    logic [8:0]  alive_count;
    logic        changed;
    logic [15:0] frame_count;

    logic [255:0] board;
    int gx, gy, shift_line, fd_cnt, passed, total, fails;

    vga_board_capture #(
        .CAP_X0(0), .CAP_Y0(0), .SAMPLE_OFS(3),
        .H_TOTAL(HT), .H_SYNC(HS), .V_TOTAL(VT), .V_SYNC(VS)
    ) dut (
        .clk(clk), .reset(reset), .vga_in(vga_in), .rd_addr(rd_addr),
        .rd_data(rd_data), .locked(locked), .frame_done(frame_done),
        .alive_count(alive_count), .changed(changed), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input int x, input int y);
        int xs;
        logic hs, vs;
        logic [7:0] c;
        xs = (y == shift_line) ? HS + 4 : HS;
        hs = !(x >= xs && x < xs + 4);
        vs = !(y == VS || y == VS + 1);
        c  = (x < 128 && y < 128) ? (board[(y / 8) * 16 + x / 8] ? 8'h33 : 8'h01) : 8'h00;
        return {hs, 3'b000, vs, 3'b000} | c;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (frame_done) fd_cnt++;
        vga_in = pix(gx, gy);
        gx++;
        if (gx == HT) begin
            gx = 0;
            gy = (gy == VT - 1) ? 0 : gy + 1;
        end
    endtask

    task automatic run_to(input int x, input int y);
        while (!(gx == x && gy == y)) step();
    endtask

    task automatic read_chk(input string tag, input logic [7:0] a, input logic exp);
        rd_addr = a;
        step();
        step();
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        clk = 0; reset = 1; vga_in = 8'h88; rd_addr = 8'h00;
        passed = 0; total = 0; fails = 0; fd_cnt = 0; shift_line = -1;
        board = '0;
        repeat (3) @(negedge clk);
        reset = 0;
        repeat (300) begin
            @(negedge clk);
            if (frame_done) fd_cnt++;
        end
        check("idle_locked", 32'(locked), 0);
        check("idle_frame_done", 32'(fd_cnt), 0);
        check("idle_alive", 32'(alive_count), 0);
        check("idle_changed", 32'(changed), 0);
        check("idle_frame_count", 32'(frame_count), 0);
        check("idle_rd_data", 32'(rd_data), 0);

        board = '0;
        board[8'h12] = 1; board[8'h23] = 1; board[8'h31] = 1; board[8'h32] = 1; board[8'h33] = 1;
        gx = 0; gy = 127;
        run_to(132, VS);
        check("lock_early", 32'(locked), 0);
        step();
        check("lock_rise", 32'(locked), 1);

        run_to(2, 128);
        check("commit_early", 32'(frame_done), 0);
        step();
        check("commit_pulse", 32'(frame_done), 1);
        step();
        check("commit_fall", 32'(frame_done), 0);
        run_to(10, 128);
        check("a_done_count", 32'(fd_cnt), 1);
        check("a_alive", 32'(alive_count), 5);
        check("a_changed", 32'(changed), 1);
        check("a_frame_count", 32'(frame_count), 1);
        read_chk("a_rd_12", 8'h12, 1'b1);
        read_chk("a_rd_23", 8'h23, 1'b1);
        read_chk("a_rd_31", 8'h31, 1'b1);
        read_chk("a_rd_32", 8'h32, 1'b1);
        read_chk("a_rd_33", 8'h33, 1'b1);
        read_chk("a_rd_22", 8'h22, 1'b0);
        read_chk("a_rd_00", 8'h00, 1'b0);

        run_to(10, 128);
        check("b_done_count", 32'(fd_cnt), 2);
        check("b_alive", 32'(alive_count), 5);
        check("b_changed", 32'(changed), 0);
        check("b_frame_count", 32'(frame_count), 2);

        board = '1;
        shift_line = 40;
        run_to(136, 40);
        check("shift_pre_locked", 32'(locked), 1);
        step();
        check("shift_unlock", 32'(locked), 0);
        run_to(0, 41);
        shift_line = -1;
        run_to(10, 128);
        check("c_no_commit", 32'(fd_cnt), 2);
        check("c_frame_count", 32'(frame_count), 2);
        check("c_alive_hold", 32'(alive_count), 5);
        run_to(0, 0);
        check("relock", 32'(locked), 1);

        run_to(10, 128);
        check("d_done_count", 32'(fd_cnt), 3);
        check("d_alive", 32'(alive_count), 256);
        check("d_changed", 32'(changed), 1);
        check("d_frame_count", 32'(frame_count), 3);
        read_chk("d_rd_ff", 8'hFF, 1'b1);
        read_chk("d_rd_00", 8'h00, 1'b1);

        rd_addr = 8'hFF;
        run_to(0, 20);
        reset = 1;
        step();
        reset = 0;
        step();
        check("rst_locked", 32'(locked), 0);
        check("rst_frame_count", 32'(frame_count), 0);
        check("rst_alive", 32'(alive_count), 0);
        check("rst_changed", 32'(changed), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        run_to(0, 40);
        check("rst_stay_unlocked", 32'(locked), 0);
        check("rst_no_commit", 32'(fd_cnt), 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
